// File: rtl/tri_bbox_seq.sv
// Triangle bounding-box sequencer: walks eight min/max compares through a single
// external fp_min unit to produce xmin/xmax/ymin/ymax for one fp16 triangle.
module tri_bbox_seq #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         nd,
  output logic         us_rfd,
  input  logic [W-1:0] x0,
  input  logic [W-1:0] y0,
  input  logic [W-1:0] x1,
  input  logic [W-1:0] y1,
  input  logic [W-1:0] x2,
  input  logic [W-1:0] y2,
  output logic         cmp_nd,
  input  logic         cmp_us_rfd,
  output logic [W-1:0] cmp_a,
  output logic [W-1:0] cmp_b,
  input  logic         cmp_rdy,
  input  logic [W-1:0] cmp_min,
  output logic         cmp_ds_rfd,
  output logic         rdy,
  input  logic         ds_rfd,
  output logic [W-1:0] xmin,
  output logic [W-1:0] xmax,
  output logic [W-1:0] ymin,
  output logic [W-1:0] ymax
);

  // Every link moves data on a cycle where its valid (nd, cmp_nd, cmp_rdy, rdy) and
  // its ready (us_rfd, cmp_us_rfd, cmp_ds_rfd, ds_rfd) are both high; valid holds its payload until then.
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [W-1:0] SIGN = {1'b1, {(W-1){1'b0}}};

  state_t       state, state_nxt;
  logic [2:0]   op;
  logic [W-1:0] t;
  logic [W-1:0] vx0, vx1, vx2, vy0, vy1, vy2;
  logic [W-1:0] xmin_r, xmax_r, ymin_r, ymax_r;
  logic [W-1:0] a_sel, b_sel, flip, res;

  // op[1] marks the max ops; max(a,b) = -min(-a,-b), t itself stays un-negated
  assign flip = op[1] ? SIGN : '0;
  assign res  = cmp_min ^ flip;

  always_comb begin
    if (op[0]) begin
      a_sel = t;
      b_sel = op[2] ? vy2 : vx2;
    end else begin
      a_sel = op[2] ? vy0 : vx0;
      b_sel = op[2] ? vy1 : vx1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (nd) state_nxt = ISSUE;
      ISSUE: if (cmp_us_rfd) state_nxt = WAIT;
      WAIT:  if (cmp_rdy) state_nxt = (op == 3'd7) ? DONE : ISSUE;
      DONE:  if (ds_rfd) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    us_rfd     = 1'b0;
    cmp_nd     = 1'b0;
    cmp_ds_rfd = 1'b0;
    rdy        = 1'b0;
    cmp_a      = '0;
    cmp_b      = '0;
    xmin       = '0;
    xmax       = '0;
    ymin       = '0;
    ymax       = '0;
    if (!rst) begin
      us_rfd     = (state == IDLE);
      cmp_nd     = (state == ISSUE);
      cmp_ds_rfd = (state == WAIT);
      rdy        = (state == DONE);
      cmp_a      = a_sel ^ flip;
      cmp_b      = b_sel ^ flip;
      xmin       = xmin_r;
      xmax       = xmax_r;
      ymin       = ymin_r;
      ymax       = ymax_r;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op     <= '0;
      t      <= '0;
      vx0    <= '0;
      vx1    <= '0;
      vx2    <= '0;
      vy0    <= '0;
      vy1    <= '0;
      vy2    <= '0;
      xmin_r <= '0;
      xmax_r <= '0;
      ymin_r <= '0;
      ymax_r <= '0;
    end else if (state == IDLE && nd) begin
      op  <= '0;
      vx0 <= x0;
      vx1 <= x1;
      vx2 <= x2;
      vy0 <= y0;
      vy1 <= y1;
      vy2 <= y2;
    end else if (state == WAIT && cmp_rdy) begin
      op <= op + 3'd1;
      if (!op[0]) begin
        t <= res;
      end else begin
        case (op[2:1])
          2'd0:    xmin_r <= res;
          2'd1:    xmax_r <= res;
          2'd2:    ymin_r <= res;
          default: ymax_r <= res;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tri_bbox_seq.sv
// Directed bench for tri_bbox_seq with a behavioural fp16 fp_min unit of
// programmable result latency and a bounding-box scoreboard.
module tb_tri_bbox_seq;

  logic        clk = 1'b0;
  logic        rst, nd, us_rfd;
  logic [15:0] x0, y0, x1, y1, x2, y2;
  logic        cmp_nd, cmp_us_rfd, cmp_rdy, cmp_ds_rfd;
  logic [15:0] cmp_a, cmp_b, cmp_min;
  logic        rdy, ds_rfd;
  logic [15:0] xmin, xmax, ymin, ymax;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [63:0] exp_q[$];

  tri_bbox_seq #(.W(16)) dut (
    .clk(clk), .rst(rst), .nd(nd), .us_rfd(us_rfd),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1), .x2(x2), .y2(y2),
    .cmp_nd(cmp_nd), .cmp_us_rfd(cmp_us_rfd), .cmp_a(cmp_a), .cmp_b(cmp_b),
    .cmp_rdy(cmp_rdy), .cmp_min(cmp_min), .cmp_ds_rfd(cmp_ds_rfd),
    .rdy(rdy), .ds_rfd(ds_rfd),
    .xmin(xmin), .xmax(xmax), .ymin(ymin), .ymax(ymax)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running required done");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", tag, got, exp);
    end
  endtask

  // fp16 ordering without NaN; -0 sorts below +0, ties return a
  function automatic logic [15:0] fp_key(input logic [15:0] v);
    return v[15] ? ~v : (v ^ 16'h8000);
  endfunction

  function automatic logic [15:0] fp_min16(input logic [15:0] a, input logic [15:0] b);
    return (fp_key(a) <= fp_key(b)) ? a : b;
  endfunction

  // fp_min model: result valid lat cycles after the request is accepted
  logic [1:0]  mcnt = 2'd0;
  logic [15:0] mres = 16'h0;
  int          lat  = 1;
  assign cmp_rdy = (mcnt == 2'd1);
  assign cmp_min = mres;

  always @(posedge clk) begin
    if (cmp_nd && cmp_us_rfd) begin
      mcnt <= 2'(lat);
      mres <= fp_min16(cmp_a, cmp_b);
    end else if (cmp_rdy && cmp_ds_rfd) begin
      mcnt <= 2'd0;
    end else if (mcnt > 2'd1) begin
      mcnt <= mcnt - 2'd1;
    end
  end

  // monitor and scoreboard, sampled mid-cycle
  int n_acc = 0, n_out = 0, n_cmp_acc = 0, n_rise = 0;
  int acc_cyc = 0, out_cyc = 0, rise_cyc = 0;
  int rst_bad = 0, busy_bad = 0, post_bad = 0, wide_bad = 0;
  logic busy = 1'b0, post_out = 1'b0, rdy_q = 1'b0, acc_q = 1'b0;
  logic [15:0] first_a = 16'h0, first_b = 16'h0;

  always @(negedge clk) begin
    if (rst) begin
      if (us_rfd || cmp_nd || cmp_ds_rfd || rdy || cmp_a != 16'h0 || cmp_b != 16'h0 ||
          {xmin, xmax, ymin, ymax} != 64'h0)
        rst_bad++;
      busy = 1'b0; post_out = 1'b0; rdy_q = 1'b0; acc_q = 1'b0;
    end else begin
      if (post_out && !us_rfd) post_bad++;
      post_out = 1'b0;
      if (busy && us_rfd) busy_bad++;
      if (acc_q && cmp_nd) wide_bad++;
      if (cmp_nd && cmp_us_rfd) begin
        if (n_cmp_acc == 0) begin
          first_a = cmp_a;
          first_b = cmp_b;
        end
        n_cmp_acc++;
      end
      if (rdy && !rdy_q) begin
        rise_cyc = cyc;
        n_rise++;
      end
      if (rdy && ds_rfd) begin
        out_cyc = cyc;
        n_out++;
        busy = 1'b0;
        post_out = 1'b1;
        if (exp_q.size() == 0) check("bbox_unexpected", 64'd1, 64'd0);
        else check("bbox", {xmin, xmax, ymin, ymax}, exp_q.pop_front());
      end
      if (nd && us_rfd) begin
        acc_cyc = cyc;
        n_acc++;
        busy = 1'b1;
        n_cmp_acc = 0;
        n_rise = 0;
      end
      rdy_q = rdy;
      acc_q = cmp_nd && cmp_us_rfd;
    end
  end

  // driver tasks
  task automatic start_tri(input logic [15:0] vx0, vx1, vx2, vy0, vy1, vy2,
                           input logic [63:0] e);
    @(posedge clk); #1;
    nd = 1'b1;
    x0 = vx0; x1 = vx1; x2 = vx2;
    y0 = vy0; y1 = vy1; y2 = vy2;
    exp_q.push_back(e);
  endtask

  task automatic wait_accept();
    logic ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      if (nd && us_rfd) ok = 1'b1;
    end
    check("accept_timeout", 64'(ok), 64'd1);
    @(posedge clk); #1;
    nd = 1'b0;
    x0 = 16'h1234; x1 = 16'h5678; x2 = 16'h2BCD;
    y0 = 16'hA111; y1 = 16'h4E22; y2 = 16'h0333;
  endtask

  task automatic wait_out(input int n_before);
    logic ok = 1'b0;
    for (int k = 0; k < 400 && !ok; k++) begin
      @(posedge clk);
      if (n_out > n_before) ok = 1'b1;
    end
    check("out_timeout", 64'(ok), 64'd1);
  endtask

  task automatic wait_cmp_acc(input int n);
    logic ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(posedge clk);
      if (n_cmp_acc == n) ok = 1'b1;
    end
    check("cmp_acc_timeout", 64'(ok), 64'd1);
  endtask

  initial begin
    int   nb, acc_before;
    logic ok;
    rst = 1'b1; nd = 1'b0; ds_rfd = 1'b1; cmp_us_rfd = 1'b1;
    x0 = '0; x1 = '0; x2 = '0; y0 = '0; y1 = '0; y2 = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_outputs_zero", 64'(rst_bad), 64'd0);
    check("us_rfd_after_rst", 64'(us_rfd), 64'd1);
    check("bbox_after_rst", {xmin, xmax, ymin, ymax}, 64'h0);

    // basic triangle, L=1
    nb = n_out;
    start_tri(16'h0000, 16'h3800, 16'hBC00, 16'h3C00, 16'h4000, 16'hC000,
              {16'hBC00, 16'h3800, 16'hC000, 16'h4000});
    wait_accept();
    wait_out(nb);
    check("basic_latency", 64'(rise_cyc - acc_cyc), 64'd17);
    check("basic_cmp_pulses", 64'(n_cmp_acc), 64'd8);
    check("basic_rdy_rises", 64'(n_rise), 64'd1);
    check("basic_first_ops", {first_a, first_b}, {16'h0000, 16'h3800});
    @(negedge clk);
    check("rdy_single_cycle", 64'(rdy), 64'd0);

    // degenerate triangle
    nb = n_out;
    start_tri(16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00,
              {16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00});
    wait_accept();
    wait_out(nb);
    check("degen_latency", 64'(rise_cyc - acc_cyc), 64'd17);

    // compare backpressure at op2, output backpressure in DONE, second triangle waiting
    @(posedge clk); #1 ds_rfd = 1'b0;
    start_tri(16'h3C00, 16'h4800, 16'h4000, 16'h0000, 16'hC400, 16'h3800,
              {16'h3C00, 16'h4800, 16'hC400, 16'h3800});
    wait_accept();
    wait_cmp_acc(2);
    #1 cmp_us_rfd = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      if (cmp_nd) ok = 1'b1;
    end
    check("stall_issue_timeout", 64'(ok), 64'd1);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      check("stall_cmp_nd", 64'(cmp_nd), 64'd1);
      check("stall_operands", {cmp_a, cmp_b}, {16'hBC00, 16'hC800});
    end
    @(posedge clk); #1 cmp_us_rfd = 1'b1;
    acc_before = n_acc;
    start_tri(16'h4000, 16'h0000, 16'h3800, 16'hB800, 16'h3400, 16'hC200,
              {16'h0000, 16'h4000, 16'hC200, 16'h3400});
    ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      if (rdy) ok = 1'b1;
    end
    check("bp_rdy_timeout", 64'(ok), 64'd1);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      check("hold_rdy", 64'(rdy), 64'd1);
      check("hold_bbox", {xmin, xmax, ymin, ymax}, {16'h3C00, 16'h4800, 16'hC400, 16'h3800});
      check("hold_no_accept", 64'(n_acc), 64'(acc_before));
    end
    @(posedge clk); #1 ds_rfd = 1'b1;
    wait_accept();
    check("b2b_accept_after_done", 64'(acc_cyc), 64'(out_cyc + 1));
    nb = n_out;
    wait_out(nb);

    // reset during WAIT of op3 with the result arriving while reset is high
    lat = 2;
    start_tri(16'h0000, 16'h3800, 16'hBC00, 16'h3C00, 16'h4000, 16'hC000,
              {16'hBC00, 16'h3800, 16'hC000, 16'h4000});
    wait_accept();
    wait_cmp_acc(4);
    rst_bad = 0;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    lat = 1;
    @(negedge clk);
    check("midop_rst_outputs_zero", 64'(rst_bad), 64'd0);
    check("midop_us_rfd_after_rst", 64'(us_rfd), 64'd1);
    check("idle_ignores_late_rdy", 64'(cmp_ds_rfd), 64'd0);
    nb = n_out;
    start_tri(16'h0000, 16'h3800, 16'hBC00, 16'h3C00, 16'h4000, 16'hC000,
              {16'hBC00, 16'h3800, 16'hC000, 16'h4000});
    wait_accept();
    wait_out(nb);
    check("restart_first_ops", {first_a, first_b}, {16'h0000, 16'h3800});
    check("restart_latency", 64'(rise_cyc - acc_cyc), 64'd17);

    repeat (3) @(posedge clk);
    check("total_outputs", 64'(n_out), 64'd5);
    check("exp_q_empty", 64'(exp_q.size()), 64'd0);
    check("us_rfd_low_while_busy", 64'(busy_bad), 64'd0);
    check("us_rfd_high_after_out", 64'(post_bad), 64'd0);
    check("cmp_nd_width", 64'(wide_bad), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
